// File: rtl/qos_wrr_sched.sv
// Four-queue weighted round-robin scheduler with zero-latency grant.
// Each queue may hold the grant for up to its weight in consecutive cycles.
module qos_wrr_sched #(
    parameter int WW = 3
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            init,
    input  logic [4*WW-1:0] WEIGHTS,
    input  logic [3:0]      fifo_empty,
    input  logic            out_full,
    output logic [3:0]      pop,
    output logic [1:0]      sel,
    output logic            valid,
    output logic            active
);

    typedef enum logic {
        WAIT_INIT,
        ACTIVE
    } state_t;

    state_t          state;
    logic [WW-1:0]   weight [4];
    logic [1:0]      ptr;
    logic [WW-1:0]   credit;

    logic [3:0]      elig;
    logic            run;
    logic            gnt;
    logic            cont;
    logic [1:0]      g;
    logic [1:0]      idx;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            elig[i] = !fifo_empty[i] && (weight[i] != '0);
        end
    end

    // Continue the current burst if it has credit, else scan from ptr+1 wrapping to ptr.
    always_comb begin
        run  = (state == ACTIVE) && !init && !out_full && !RESET;
        gnt  = 1'b0;
        cont = 1'b0;
        g    = ptr;
        idx  = ptr;
        if (run) begin
            if (elig[ptr] && (credit != '0)) begin
                gnt  = 1'b1;
                cont = 1'b1;
            end else begin
                for (int k = 1; k <= 4; k++) begin
                    idx = ptr + 2'(k);
                    if (!gnt && elig[idx]) begin
                        gnt = 1'b1;
                        g   = idx;
                    end
                end
            end
        end
    end

    always_comb begin
        pop    = gnt ? (4'b0001 << g) : 4'b0000;
        valid  = gnt;
        sel    = RESET ? 2'd3 : g;
        active = (state == ACTIVE) && !RESET;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state  <= WAIT_INIT;
            ptr    <= 2'd3;
            credit <= '0;
            for (int i = 0; i < 4; i++) begin
                weight[i] <= '0;
            end
        end else if (init) begin
            state  <= ACTIVE;
            ptr    <= 2'd3;
            credit <= '0;
            for (int i = 0; i < 4; i++) begin
                weight[i] <= WEIGHTS[i*WW +: WW];
            end
        end else if (gnt) begin
            if (cont) begin
                credit <= credit - WW'(1);
            end else begin
                ptr    <= g;
                credit <= weight[g] - WW'(1);
            end
        end
    end

endmodule

// File: tb/tb_qos_wrr_sched.sv
// Directed bench for qos_wrr_sched: reset, rotation, backpressure, re-init.
module tb_qos_wrr_sched;

    localparam int WW = 3;

    logic            CLK = 1'b0;
    logic            RESET;
    logic            init;
    logic [4*WW-1:0] WEIGHTS;
    logic [3:0]      fifo_empty;
    logic            out_full;
    logic [3:0]      pop;
    logic [1:0]      sel;
    logic            valid;
    logic            active;

    int n_assert = 0;
    int n_fail   = 0;

    qos_wrr_sched #(.WW(WW)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .init      (init),
        .WEIGHTS   (WEIGHTS),
        .fifo_empty(fifo_empty),
        .out_full  (out_full),
        .pop       (pop),
        .sel       (sel),
        .valid     (valid),
        .active    (active)
    );

    always #5 CLK = ~CLK;

    function automatic logic [4*WW-1:0] wts(input int w0, input int w1,
                                            input int w2, input int w3);
        return {WW'(w3), WW'(w2), WW'(w1), WW'(w0)};
    endfunction

    task automatic cyc(input string tag, input logic [3:0] ep,
                       input logic [1:0] es, input logic ea);
        @(negedge CLK);
        n_assert++;
        assert (pop === ep) else begin
            n_fail++;
            $error("FAIL %s pop observed=%b expected=%b", tag, pop, ep);
        end
        n_assert++;
        assert (valid === (ep != 4'b0)) else begin
            n_fail++;
            $error("FAIL %s valid observed=%b expected=%b", tag, valid, ep != 4'b0);
        end
        n_assert++;
        assert (sel === es) else begin
            n_fail++;
            $error("FAIL %s sel observed=%0d expected=%0d", tag, sel, es);
        end
        n_assert++;
        assert (active === ea) else begin
            n_fail++;
            $error("FAIL %s active observed=%b expected=%b", tag, active, ea);
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic grant(input string tag, input int q);
        cyc(tag, 4'b0001 << q, 2'(q), 1'b1);
    endtask

    task automatic do_init(input string tag, input logic [4*WW-1:0] w,
                           input logic [1:0] es, input logic ea);
        init    = 1'b1;
        WEIGHTS = w;
        cyc(tag, 4'b0000, es, ea);
        init    = 1'b0;
    endtask

    initial begin
        int seq_rot [11];
        seq_rot = '{0, 0, 0, 1, 2, 2, 3, 0, 0, 0, 1};

        RESET      = 1'b1;
        init       = 1'b0;
        WEIGHTS    = '0;
        fifo_empty = 4'b0000;
        out_full   = 1'b0;

        // reset and the cycle after
        cyc("reset0", 4'b0000, 2'd3, 1'b0);
        cyc("reset1", 4'b0000, 2'd3, 1'b0);
        RESET = 1'b0;
        cyc("post_reset", 4'b0000, 2'd3, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cyc("no_init", 4'b0000, 2'd3, 1'b0);
        end

        // weighted rotation 3,1,2,1
        do_init("init_rot", wts(3, 1, 2, 1), 2'd3, 1'b0);
        for (int i = 0; i < 11; i++) begin
            grant("rot", seq_rot[i]);
        end

        // backpressure after second q0 grant
        do_init("init_bp", wts(3, 1, 2, 1), 2'd1, 1'b1);
        grant("bp_g0a", 0);
        grant("bp_g0b", 0);
        out_full = 1'b1;
        cyc("bp_stall0", 4'b0000, 2'd0, 1'b1);
        cyc("bp_stall1", 4'b0000, 2'd0, 1'b1);
        out_full = 1'b0;
        grant("bp_resume0", 0);
        grant("bp_resume1", 1);
        grant("bp_resume2", 2);
        grant("bp_resume3", 2);

        // q1 disabled by zero weight
        do_init("init_dis", wts(2, 0, 1, 1), 2'd2, 1'b1);
        grant("dis0", 0);
        grant("dis1", 0);
        grant("dis2", 2);
        grant("dis3", 3);
        grant("dis4", 0);
        grant("dis5", 0);
        grant("dis6", 2);

        // only q2 busy with weight 1
        fifo_empty = 4'b1011;
        do_init("init_single", wts(3, 1, 1, 1), 2'd2, 1'b1);
        for (int i = 0; i < 5; i++) begin
            grant("single_q2", 2);
        end

        // nothing eligible: sel follows ptr
        fifo_empty = 4'b1111;
        cyc("all_empty0", 4'b0000, 2'd2, 1'b1);
        cyc("all_empty1", 4'b0000, 2'd2, 1'b1);

        // q0 empties mid-burst and forfeits credit
        fifo_empty = 4'b0000;
        do_init("init_forfeit", wts(3, 1, 2, 1), 2'd2, 1'b1);
        grant("forfeit_g0", 0);
        fifo_empty = 4'b0001;
        grant("forfeit_g1", 1);
        grant("burst_q2", 2);

        // init during q2 burst
        fifo_empty = 4'b0000;
        do_init("init_mid", wts(1, 1, 1, 1), 2'd2, 1'b1);
        grant("mid0", 0);
        grant("mid1", 1);
        grant("mid2", 2);
        grant("mid3", 3);

        // all weights zero
        do_init("init_zero", wts(0, 0, 0, 0), 2'd3, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cyc("zero_w", 4'b0000, 2'd3, 1'b1);
        end

        // reset during q0 burst
        do_init("init_rst", wts(3, 1, 2, 1), 2'd3, 1'b1);
        grant("rst_g0a", 0);
        grant("rst_g0b", 0);
        RESET = 1'b1;
        cyc("rst_mid", 4'b0000, 2'd3, 1'b0);
        RESET = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc("rst_wait", 4'b0000, 2'd3, 1'b0);
        end
        do_init("init_after_rst", wts(3, 1, 2, 1), 2'd3, 1'b0);
        grant("after_rst", 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
